// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants, segment bit names and hex pattern table
package seg7_pkg;

    typedef enum logic [2:0] {
        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G
    } seg_bit_e;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_ALL = 7'h7F;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational 4-bit hex to active-high 7-segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    assign pattern = HEX_TABLE[value];

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed hex display driver with dead time and leading-zero blanking
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 100000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int LZ_SUPPRESS    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_INV = ACTIVE_LOW_SEG != 0 ? SEG_ALL : SEG_OFF;
    localparam logic DP_INV = ACTIVE_LOW_SEG != 0;
    localparam logic [NUM_DIGITS-1:0] AN_INV = ACTIVE_LOW_AN != 0 ? '1 : '0;

    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   sh_digits;
    logic [NUM_DIGITS-1:0]     sh_dp, sh_blank, lz_dark, an_hot;
    logic [3:0]                nib;
    logic [6:0]                pattern;
    logic                      slot_end, frame_end, frame_start, lit, run;
    logic                      sel_dark, sel_blank, sel_dp;

    assign slot_end    = cnt == CNT_LAST;
    assign frame_end   = slot_end && idx == IDX_LAST;
    assign frame_start = cnt == '0 && idx == '0;
    assign lit         = en && cnt != '0;

    // Prescaler and round-robin digit index; both freeze while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
        end
    end

    // Shadow inputs once per frame during its dead first cycle so a frame never mixes values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
        end else if (en && frame_start) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
        end
    end

    // Leading-zero mask: digit k>0 is dark when it and every higher digit are zero
    always_comb begin
        lz_dark = '0;
        run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run = run && sh_digits[4*k +: 4] == 4'h0;
            lz_dark[k] = run && LZ_SUPPRESS != 0;
        end
    end

    // Select the current digit's shadow fields and its one-hot anode
    always_comb begin
        nib       = '0;
        sel_dark  = 1'b0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        an_hot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib       = sh_digits[4*k +: 4];
                sel_dark  = sh_blank[k] || lz_dark[k];
                sel_blank = sh_blank[k];
                sel_dp    = sh_dp[k];
                an_hot[k] = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .value   (nib),
        .pattern (pattern)
    );

    // Registered pin drivers; the dead cycle and disabled state keep everything unlit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_INV;
            dp_out     <= DP_INV;
            an_out     <= AN_INV;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= (lit && !sel_dark ? pattern : SEG_OFF) ^ SEG_INV;
            dp_out     <= (lit && sel_dp && !sel_blank) ^ DP_INV;
            an_out     <= (lit ? an_hot : '0) ^ AN_INV;
            frame_done <= en && frame_end;
        end
    end

endmodule
